polyshift_pipe: RTL and testbench

Pipelined, bidirectional successor to `polyshift_r`: one shifter for right and left shifts in all four `SHIFT_TYPE` modes, with the barrel network split across a configurable number of register stages. It sits between an operand-issue stage and a writeback/flag stage, joined by valid/ready handshakes on both sides. It accepts one operation per cycle and returns results in order with fixed latency when not stalled.

---
 rtl/polyshift_pkg.sv | 26 ++
 rtl/polyshift_stage.sv | 87 ++++++++
 rtl/polyshift_pipe.sv | 106 ++++++++++
 tb/tb_polyshift_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/polyshift_pkg.sv
// Shared types and helpers for the pipelined bidirectional shifter.
// Carry-out support is selected at build time by POLYSHIFT_CARRY_OUT_EN.
package polyshift_pkg;

  typedef enum logic [1:0] {LOGIC, ARITH, RCR, ROR} SHIFT_TYPE;
  typedef enum logic {RIGHT, LEFT} SHIFT_DIR;

  // Wide enough for any supported word width (up to 256 bits).
  localparam int unsigned ShamtMaxW = 8;

  typedef struct packed {
    SHIFT_TYPE             shift_type;
    SHIFT_DIR              shift_dir;
    logic [ShamtMaxW-1:0]  shamt;
  } polyshift_op_t;

  // Shift-amount bits consumed by stage j; earlier stages take the larger groups.
  function automatic int unsigned grp_bits(int unsigned l, int unsigned n, int unsigned j);
    return l / n + ((j < l % n) ? 1 : 0);
  endfunction

  function automatic int unsigned grp_off(int unsigned l, int unsigned n, int unsigned j);
    return j * (l / n) + ((j < l % n) ? j : l % n);
  endfunction

endpackage

// File: rtl/polyshift_stage.sv
// One pipeline stage: partial right-shift over a group of shift bits plus valid/ready register.
// Carry tracking exists only with POLYSHIFT_CARRY_OUT_EN.
module polyshift_stage
  import polyshift_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned ShW   = 3,
  parameter int unsigned Off   = 0,
  parameter int unsigned Nb    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [2*Width-2:0]   i_vec,
  input  polyshift_op_t        i_op,
`ifdef POLYSHIFT_CARRY_OUT_EN
  input  logic                 i_carry,
  output logic                 o_carry,
`endif
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [2*Width-2:0]   o_vec,
  output polyshift_op_t        o_op
);

  localparam int unsigned VecW = 2 * Width - 1;

  logic [ShW-1:0]  w_amt;
  logic [VecW-1:0] w_vec;
  polyshift_op_t   w_op;

  logic            r_valid;
  logic [VecW-1:0] r_vec;
  polyshift_op_t   r_op;

`ifdef POLYSHIFT_CARRY_OUT_EN
  logic [VecW:0]   w_sh;
  logic            w_carry;
  logic            r_carry;
`endif

  always_comb begin
    w_amt = '0;
    w_amt[Off +: Nb] = i_op.shamt[Off +: Nb];
    w_op = i_op;
    w_op.shamt[Off +: Nb] = '0;
`ifdef POLYSHIFT_CARRY_OUT_EN
    // The carry rides below bit 0 so the last bit shifted out lands in w_sh[0].
    w_sh    = {i_vec, i_carry} >> w_amt;
    w_vec   = w_sh[VecW:1];
    w_carry = w_sh[0];
`else
    w_vec = i_vec >> w_amt;
`endif
  end

  assign o_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_op    <= '0;
`ifdef POLYSHIFT_CARRY_OUT_EN
      r_carry <= 1'b0;
`endif
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_vec <= w_vec;
        r_op  <= w_op;
`ifdef POLYSHIFT_CARRY_OUT_EN
        r_carry <= w_carry;
`endif
      end
    end
  end

  assign o_valid = r_valid;
  assign o_vec   = r_vec;
  assign o_op    = r_op;
`ifdef POLYSHIFT_CARRY_OUT_EN
  assign o_carry = r_carry;
`endif

endmodule

// File: rtl/polyshift_pipe.sv
// Pipelined bidirectional shifter (LOGIC/ARITH/RCR/ROR) with valid/ready on both sides.
// Optional C_OUT port is enabled by defining POLYSHIFT_CARRY_OUT_EN.
module polyshift_pipe
  import polyshift_pkg::*;
#(
  parameter int unsigned word_width = 8,
  parameter int unsigned stages     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [word_width-1:0]         D_IN,
  input  logic [word_width-2:0]         C_IN,
  input  logic [$clog2(word_width)-1:0] shift_size,
  input  SHIFT_TYPE                     shift_type,
  input  SHIFT_DIR                      shift_dir,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
`ifdef POLYSHIFT_CARRY_OUT_EN
  output logic                          C_OUT,
`endif
  output logic [word_width-1:0]         D_OUT
);

  localparam int unsigned ShW  = $clog2(word_width);
  localparam int unsigned VecW = 2 * word_width - 1;

  logic [word_width-1:0] w_d_rev, w_d, w_res, w_res_rev;
  logic [word_width-2:0] w_c_rev, w_c, w_ext;
  SHIFT_TYPE             w_type;

  logic                  w_valid [stages+1];
  logic                  w_rdy   [stages+1];
  logic [VecW-1:0]       w_vec   [stages+1];
  polyshift_op_t         w_op    [stages+1];
`ifdef POLYSHIFT_CARRY_OUT_EN
  logic                  w_carry [stages+1];
`endif
  logic                  w_unused;

  // LEFT runs the right-shift network on bit-reversed operands; the fill word sits above D.
  always_comb begin
    w_d_rev = {<<{D_IN}};
    w_c_rev = {<<{C_IN}};
    w_d     = (shift_dir == LEFT) ? w_d_rev : D_IN;
    w_c     = (shift_dir == LEFT) ? w_c_rev : C_IN;
    w_type  = (shift_dir == LEFT && shift_type == ARITH) ? LOGIC : shift_type;
    unique case (w_type)
      LOGIC:   w_ext = '0;
      ARITH:   w_ext = {(word_width-1){w_d[word_width-1]}};
      RCR:     w_ext = w_c;
      ROR:     w_ext = w_d[word_width-2:0];
      default: w_ext = '0;
    endcase
  end

  assign w_valid[0]      = IN_VALID;
  assign w_vec[0]        = {w_ext, w_d};
  assign w_op[0]         = '{shift_type: w_type, shift_dir: shift_dir,
                             shamt: ShamtMaxW'(shift_size)};
  assign w_rdy[stages]   = OUT_READY;
  assign IN_READY        = w_rdy[0];
`ifdef POLYSHIFT_CARRY_OUT_EN
  assign w_carry[0]      = 1'b0;
`endif

  for (genvar j = 0; j < stages; j++) begin : g_stage
    polyshift_stage #(
      .Width (word_width),
      .ShW   (ShW),
      .Off   (grp_off(ShW, stages, j)),
      .Nb    (grp_bits(ShW, stages, j))
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_valid[j]),
      .o_ready (w_rdy[j]),
      .i_vec   (w_vec[j]),
      .i_op    (w_op[j]),
`ifdef POLYSHIFT_CARRY_OUT_EN
      .i_carry (w_carry[j]),
      .o_carry (w_carry[j+1]),
`endif
      .o_valid (w_valid[j+1]),
      .i_ready (w_rdy[j+1]),
      .o_vec   (w_vec[j+1]),
      .o_op    (w_op[j+1])
    );
  end

  always_comb begin
    w_res     = w_vec[stages][word_width-1:0];
    w_res_rev = {<<{w_res}};
    D_OUT     = (w_op[stages].shift_dir == LEFT) ? w_res_rev : w_res;
  end

  assign OUT_VALID = w_valid[stages];
`ifdef POLYSHIFT_CARRY_OUT_EN
  assign C_OUT     = w_carry[stages];
`endif

  assign w_unused = ^{w_vec[stages][VecW-1:word_width], w_op[stages].shift_type,
                      w_op[stages].shamt};

endmodule

// File: tb/tb_polyshift_pipe.sv
// Self-checking bench for polyshift_pipe (w=8, stages=2); carry checks need POLYSHIFT_CARRY_OUT_EN.
module tb_polyshift_pipe;
  import polyshift_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [7:0] D_IN, D_OUT;
  logic [6:0] C_IN;
  logic [2:0] shift_size;
  SHIFT_TYPE  shift_type;
  SHIFT_DIR   shift_dir;
`ifdef POLYSHIFT_CARRY_OUT_EN
  logic       C_OUT;
`else
  logic       C_OUT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic       have_prev = 1'b0;
  logic [8:0] prev_out;
  logic       rnd_en = 1'b0;

  polyshift_pipe #(.word_width(8), .stages(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .D_IN       (D_IN),
    .C_IN       (C_IN),
    .shift_size (shift_size),
    .shift_type (shift_type),
    .shift_dir  (shift_dir),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
`ifdef POLYSHIFT_CARRY_OUT_EN
    .C_OUT      (C_OUT),
`endif
    .D_OUT      (D_OUT)
  );

  always #5 clk = ~clk;

  // Reference: {carry, result} straight from the shift definitions.
  function automatic logic [8:0] model(input logic [7:0] d, input logic [6:0] c, input int s,
                                       input SHIFT_TYPE t, input SHIFT_DIR dr);
    logic [7:0]  r;
    logic [14:0] x;
    logic [15:0] y;
    logic        cy;
    r = d;
    if (dr == RIGHT) begin
      case (t)
        LOGIC: r = d >> s;
        ARITH: r = $signed(d) >>> s;
        RCR:   begin x = {c, d} >> s; r = x[7:0]; end
        ROR:   begin y = {d, d} >> s; r = y[7:0]; end
        default: r = d;
      endcase
    end else begin
      case (t)
        LOGIC, ARITH: r = d << s;
        RCR:   begin x = {d, c} << s; r = x[14:7]; end
        ROR:   begin y = {d, d} << s; r = y[15:8]; end
        default: r = d;
      endcase
    end
    if (s == 0) cy = 1'b0;
    else if (dr == RIGHT) cy = d[s-1];
    else cy = d[8-s];
    return {cy, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every drained result against the model, plus stall stability.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("stall_hold_d", {24'h0, D_OUT}, {24'h0, prev_out[7:0]});
`ifdef POLYSHIFT_CARRY_OUT_EN
        chk("stall_hold_c", {31'h0, C_OUT}, {31'h0, prev_out[8]});
`endif
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, {31'h0, exp_q.size() == 0 ? 1'b0 : 1'b1});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("model_d", {24'h0, D_OUT}, {24'h0, e[7:0]});
`ifdef POLYSHIFT_CARRY_OUT_EN
          chk("model_c", {31'h0, C_OUT}, {31'h0, e[8]});
`endif
        end
      end
      have_prev = OUT_VALID && !OUT_READY;
      prev_out  = {C_OUT, D_OUT};
      if (IN_VALID && IN_READY)
        exp_q.push_back(model(D_IN, C_IN, int'(shift_size), shift_type, shift_dir));
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      OUT_READY = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drive(input logic [7:0] d, input logic [6:0] c, input logic [2:0] s,
                       input SHIFT_TYPE t, input SHIFT_DIR dr);
    D_IN = d; C_IN = c; shift_size = s; shift_type = t; shift_dir = dr;
    IN_VALID = 1'b1;
  endtask

  task automatic issue(input logic [7:0] d, input logic [6:0] c, input logic [2:0] s,
                       input SHIFT_TYPE t, input SHIFT_DIR dr);
    int n;
    drive(d, c, s, t, dr);
    n = 0;
    @(negedge clk);
    while (!IN_READY && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!IN_READY) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: IN_READY stayed %0b, required 1", IN_READY);
    end
    @(posedge clk);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic run_check(input string nm, input logic [7:0] d, input logic [6:0] c,
                           input logic [2:0] s, input SHIFT_TYPE t, input SHIFT_DIR dr,
                           input logic [7:0] exp_d, input logic exp_c);
    int lat;
    issue(d, c, s, t, dr);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!OUT_VALID && lat < 20);
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_d"}, {24'h0, D_OUT}, {24'h0, exp_d});
`ifdef POLYSHIFT_CARRY_OUT_EN
    chk({nm, "_c"}, {31'h0, C_OUT}, {31'h0, exp_c});
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
    D_IN = '0; C_IN = '0; shift_size = '0; shift_type = LOGIC; shift_dir = RIGHT;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'h0, OUT_VALID}, 0);
    chk("reset_d_out", {24'h0, D_OUT}, 0);
    chk("reset_c_out", {31'h0, C_OUT}, 0);
    chk("reset_in_ready", {31'h0, IN_READY}, 1);
    @(posedge clk);
    #1;

    run_check("r_arith", 8'b1001_0110, 7'h00, 3'd3, ARITH, RIGHT, 8'b1111_0010, 1'b1);
    run_check("l_rcr", 8'hA5, 7'b1100110, 3'd2, RCR, LEFT, 8'b1001_0111, 1'b0);
    run_check("l_ror", 8'h81, 7'h00, 3'd1, ROR, LEFT, 8'h03, 1'b1);
    run_check("l_arith", 8'h81, 7'h00, 3'd1, ARITH, LEFT, 8'h02, 1'b1);
    run_check("r_rcr", 8'h0F, 7'b101_0101, 3'd4, RCR, RIGHT, 8'h50, 1'b1);
    run_check("r_ror", 8'h01, 7'h00, 3'd7, ROR, RIGHT, 8'h02, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run_check("s0", 8'h5A, 7'h33, 3'd0, SHIFT_TYPE'(k % 4), SHIFT_DIR'(k / 4), 8'h5A, 1'b0);
    end

    // Backpressure: two accepted, third waits and enters on the first drain.
    OUT_READY = 1'b0;
    issue(8'hF0, 7'h00, 3'd4, LOGIC, RIGHT);
    issue(8'h12, 7'h00, 3'd4, ROR, RIGHT);
    drive(8'h01, 7'h00, 3'd7, LOGIC, LEFT);
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", {31'h0, IN_READY}, 0);
      chk("full_out_valid", {31'h0, OUT_VALID}, 1);
    end
    @(posedge clk);
    #1 OUT_READY = 1'b1;
    @(negedge clk);
    chk("drain_accept_in_ready", {31'h0, IN_READY}, 1);
    chk("drain_first_d", {24'h0, D_OUT}, 32'h0F);
    @(posedge clk);
    #1 IN_VALID = 1'b0;
    @(negedge clk);
    chk("drain_second_valid", {31'h0, OUT_VALID}, 1);
    chk("drain_second_d", {24'h0, D_OUT}, 32'h21);
    @(negedge clk);
    chk("drain_third_valid", {31'h0, OUT_VALID}, 1);
    chk("drain_third_d", {24'h0, D_OUT}, 32'h80);
    @(negedge clk);
    chk("drain_empty", {31'h0, OUT_VALID}, 0);
    @(posedge clk);
    #1;

    // Reset with two ops in flight.
    OUT_READY = 1'b0;
    issue(8'h77, 7'h00, 3'd1, LOGIC, RIGHT);
    issue(8'h66, 7'h00, 3'd2, LOGIC, LEFT);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    OUT_READY = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("reset_flush_valid", {31'h0, OUT_VALID}, 0);
      chk("reset_flush_d", {24'h0, D_OUT}, 0);
    end
    @(posedge clk);
    #1;

    // Mixed stream with random backpressure, checked by the model.
    rnd_en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      issue(8'(k * 37 + 11), 7'(k * 19 + 5), 3'(k % 8), SHIFT_TYPE'(k % 4), SHIFT_DIR'((k / 4) % 2));
    end
    rnd_en = 1'b0;
    @(posedge clk);
    #2 OUT_READY = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    chk("stream_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
